// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and width default for the divide sequencer
package div_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_ITER  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    LOAD  = S_LOAD,
    CHECK = S_CHECK,
    ITER  = S_ITER,
    DONE  = S_DONE
  } state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift/trial-subtract/select step on the {hi,lo} working register
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2*WIDTH-1:0] work_in,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] work_out
);

  logic [2*WIDTH-1:0] shifted;
  logic [WIDTH:0]     trial;

  always_comb begin
    shifted  = {work_in[2*WIDTH-2:0], 1'b0};
    trial    = {1'b0, shifted[2*WIDTH-1:WIDTH]} - {1'b0, divisor};
    work_out = shifted;
    // No borrow means the shifted remainder covers the divisor: keep the difference, emit a 1
    if (!trial[WIDTH]) begin
      work_out[2*WIDTH-1:WIDTH] = trial[WIDTH-1:0];
      work_out[0]               = 1'b1;
    end
  end

endmodule

// File: rtl/divide_sequencer.sv
// rtl/divide_sequencer.sv - unsigned restoring divider FSM driving the divisor register load
module divide_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor_value,
  output logic             div_wrctrl,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] work_q, work_d, step_next;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   quot_q, quot_d, rem_q, rem_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, busy_d, done_q, done_d, wr_q, wr_d;

  div_step #(.WIDTH(WIDTH)) u_step (
    .work_in  (work_q),
    .divisor  (divisor_value),
    .work_out (step_next)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = {{WIDTH{1'b0}}, dividend};
          state_d = LOAD;
        end
      end
      LOAD: state_d = CHECK;
      CHECK: begin
        if (divisor_value == '0) begin
          quot_d  = '1;
          rem_d   = work_q[WIDTH-1:0];
          dbz_d   = 1'b1;
          state_d = DONE;
        end else begin
          dbz_d   = 1'b0;
          cnt_d   = '0;
          state_d = ITER;
        end
      end
      ITER: begin
        work_d = step_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          quot_d  = step_next[WIDTH-1:0];
          rem_d   = step_next[2*WIDTH-1:WIDTH];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with the state they describe
    busy_d = (state_d == LOAD) || (state_d == CHECK) || (state_d == ITER);
    done_d = (state_d == DONE);
    wr_d   = (state_d == LOAD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wr_q    <= wr_d;
    end
  end

  assign div_wrctrl  = wr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;

endmodule

// File: tb/tb_divide_sequencer.sv
// tb/tb_divide_sequencer.sv - scoreboard bench with an arithmetic reference model and divisor register model
module tb_divide_sequencer;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           done_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] div_reg = '0;
  logic [W-1:0] div_reg_in = '0;
  logic         div_wrctrl, busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   wr_exp[$];

  divide_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .dividend      (dividend),
    .divisor_value (div_reg),
    .div_wrctrl    (div_wrctrl),
    .busy          (busy),
    .done          (done),
    .div_by_zero   (div_by_zero),
    .quotient      (quotient),
    .remainder     (remainder)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (div_wrctrl) div_reg <= div_reg_in;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result or a divisor load
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending division (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", W'(div_by_zero), W'(e.dbz));
        check("done_cycle", W'(cyc), W'(e.done_cyc));
      end
    end
    if (!rst && div_wrctrl) begin
      if (wr_exp.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_wrctrl: got div_wrctrl=1 expected 0 (cycle %0d)", cyc);
      end else begin
        check("wrctrl_cycle", W'(cyc), W'(wr_exp.pop_front()));
      end
    end
  end

  // Issues a start and pushes the reference result; returns the cycle number of the accept edge
  task automatic issue(input logic [W-1:0] n, input logic [W-1:0] d, output int acc);
    exp_t e;
    @(negedge clk);
    div_reg_in = d;
    dividend   = n;
    start      = 1'b1;
    acc        = cyc;
    e.q        = (d == 0) ? '1 : n / d;
    e.r        = (d == 0) ? n : n % d;
    e.dbz      = (d == 0);
    e.done_cyc = acc + ((d == 0) ? 3 : W + 3);
    sb.push_back(e);
    wr_exp.push_back(acc + 1);
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || wr_exp.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || wr_exp.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout: got %0d results pending expected 0", sb.size());
      sb.delete();
      wr_exp.delete();
    end
  endtask

  initial begin
    int acc;
    logic [W-1:0] n, d;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_wrctrl", W'(div_wrctrl), '0);
    check("rst_dbz", W'(div_by_zero), '0);
    check("rst_quotient", quotient, '0);
    check("rst_remainder", remainder, '0);

    issue(32'd100, 32'd7, acc);           wait_idle();
    issue(32'd50, 32'd9832, acc);         wait_idle();
    issue(32'hFFFF_FFFF, 32'd1, acc);     wait_idle();
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, acc); wait_idle();
    issue(32'd1234, 32'd0, acc);          wait_idle();

    // Starts in the middle of ITER and in the DONE cycle must both be ignored
    issue(32'd100, 32'd7, acc);
    while (cyc < acc + 10) @(negedge clk);
    check("busy_mid", W'(busy), 32'd1);
    start = 1'b1; dividend = 32'd9;
    @(negedge clk);
    start = 1'b0;
    while (cyc < acc + W + 3) @(negedge clk);
    start = 1'b1; dividend = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    issue(32'd77, 32'd5, acc);            wait_idle();

    // Reset in cycle 20 aborts the division with no done pulse
    issue(32'd100, 32'd7, acc);
    while (cyc < acc + 20) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("abort_busy", W'(busy), '0);
    check("abort_done", W'(done), '0);
    check("abort_quotient", quotient, '0);
    check("abort_remainder", remainder, '0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'd100, 32'd7, acc);           wait_idle();

    for (int i = 0; i < 25; i++) begin
      n = $urandom;
      case ($urandom_range(0, 3))
        0:       d = 32'($urandom_range(0, 15));
        1:       d = $urandom >> $urandom_range(0, 31);
        2:       d = n + 32'($urandom_range(0, 3));
        default: d = $urandom;
      endcase
      issue(n, d, acc);
      wait_idle();
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
